// File: rtl/y86_reg_scoreboard.sv
// y86_reg_scoreboard
//   Issue-side hazard controller for the Y86 register file. Keeps a small
//   pending-write counter per GPR, holds issue while a source register has a
//   write outstanding (or a destination counter would overflow), and runs a
//   RUN/DRAIN/DRAINED handshake so the pipeline can be quiesced on request.
//
// Ports
//   clk_i, rst_i              clock; asynchronous active-high reset
//   issue_valid_i             decode presents an instruction
//   srcA_i, srcB_i            source registers (0xF = none)
//   dstE_i, dstM_i            destination registers (0xF = none)
//   issue_ready_o             instruction may issue this cycle (combinational)
//   wbE_valid_i, wbE_reg_i    valE write-back
//   wbM_valid_i, wbM_reg_i    valM write-back
//   drain_i                   level request to quiesce issue
//   drained_o                 registered; high while no writes are outstanding
//                             and issue is blocked
//   busy_o                    bit i set while counter i is nonzero
//   stall_cnt_o               saturating count of stalled issue cycles
//   clr_stats_i               synchronous clear of stall_cnt_o
//   err_o                     sticky write-back underflow error
module y86_reg_scoreboard #(
  parameter int NREG    = 15,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  input  logic [3:0]         srcA_i,
  input  logic [3:0]         srcB_i,
  input  logic [3:0]         dstE_i,
  input  logic [3:0]         dstM_i,
  output logic               issue_ready_o,
  input  logic               wbE_valid_i,
  input  logic [3:0]         wbE_reg_i,
  input  logic               wbM_valid_i,
  input  logic [3:0]         wbM_reg_i,
  input  logic               drain_i,
  output logic               drained_o,
  output logic [NREG-1:0]    busy_o,
  output logic [STALL_W-1:0] stall_cnt_o,
  input  logic               clr_stats_i,
  output logic               err_o
);

  // Two extra bits let cnt + 2 and the wb decrement be compared without wrap.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DRAINED
  } state_t;

  state_t               state_reg;
  logic                 drained_reg;
  logic                 err_reg;
  logic [STALL_W-1:0]   stall_reg;

  logic [CNT_W-1:0]     cnt_reg  [NREG];
  logic [CNT_W-1:0]     cnt_view [16];
  logic [15:0]          trk;
  logic [NREG-1:0]      under_vec;
  logic                 fire;
  logic                 all_idle;

  // 16-entry view of the counters indexed directly by a 4-bit register id.
  // Untracked ids (0xF, or beyond NREG) read as zero and are flagged in trk
  // so they never stall and never touch a counter.
  for (genvar gi = 0; gi < 16; gi++) begin : g_view
    if (gi < NREG && gi != 15) begin : g_trk
      assign cnt_view[gi] = cnt_reg[gi];
      assign trk[gi]      = 1'b1;
    end else begin : g_untrk
      assign cnt_view[gi] = '0;
      assign trk[gi]      = 1'b0;
    end
  end

  // Issue gating
  logic             same_dst;
  logic [SUM_W-1:0] inc_e;
  logic [SUM_W-1:0] inc_m;
  logic             src_ok;
  logic             dst_e_ok;
  logic             dst_m_ok;

  always_comb begin
    same_dst = trk[dstE_i] && (dstE_i == dstM_i);
    // A dual write to one register (popl %rsp) needs room for two.
    inc_e    = same_dst ? SUM_W'(2) : SUM_W'(1);
    inc_m    = inc_e;
    src_ok   = (cnt_view[srcA_i] == '0) && (cnt_view[srcB_i] == '0);
    dst_e_ok = !trk[dstE_i] || ((SUM_W'(cnt_view[dstE_i]) + inc_e) <= CNT_MAX);
    dst_m_ok = !trk[dstM_i] || ((SUM_W'(cnt_view[dstM_i]) + inc_m) <= CNT_MAX);
    issue_ready_o = (state_reg == ST_RUN) && !drain_i && src_ok && dst_e_ok && dst_m_ok;
  end

  assign fire = issue_valid_i && issue_ready_o;

  // Per-register counters. Issue and write-back in the same cycle net out;
  // the decrement is applied to cnt + inc so that case never flags underflow.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
    localparam bit TRACKED = (gi != 15);
    logic [SUM_W-1:0] inc;
    logic [SUM_W-1:0] dec;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
      inc = SUM_W'(TRACKED && fire && (dstE_i == 4'(gi)))
          + SUM_W'(TRACKED && fire && (dstM_i == 4'(gi)));
      dec = SUM_W'(TRACKED && wbE_valid_i && (wbE_reg_i == 4'(gi)))
          + SUM_W'(TRACKED && wbM_valid_i && (wbM_reg_i == 4'(gi)));
      sum = SUM_W'(cnt_reg[gi]) + inc;
      under_vec[gi] = dec > sum;
      cnt_next = under_vec[gi] ? '0 : CNT_W'(sum - dec);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_reg[gi] <= '0;
      end else begin
        cnt_reg[gi] <= cnt_next;
      end
    end

    assign busy_o[gi] = (cnt_reg[gi] != '0);
  end

  assign all_idle = ~|busy_o;

  // FSM, error flag and stall statistics
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_RUN;
      drained_reg <= 1'b0;
      err_reg     <= 1'b0;
      stall_reg   <= '0;
    end else begin
      if (|under_vec) begin
        err_reg <= 1'b1;
      end

      if (clr_stats_i) begin
        stall_reg <= '0;
      end else if ((state_reg == ST_RUN) && issue_valid_i && !issue_ready_o
                   && (stall_reg != '1)) begin
        stall_reg <= stall_reg + 1'b1;
      end

      case (state_reg)
        ST_RUN: begin
          if (drain_i) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Dropping the request wins over completing the drain.
          if (!drain_i) begin
            state_reg <= ST_RUN;
          end else if (all_idle) begin
            state_reg   <= ST_DRAINED;
            drained_reg <= 1'b1;
          end
        end
        ST_DRAINED: begin
          if (!drain_i) begin
            state_reg   <= ST_RUN;
            drained_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_RUN;
          drained_reg <= 1'b0;
        end
      endcase
    end
  end

  assign drained_o   = drained_reg;
  assign err_o       = err_reg;
  assign stall_cnt_o = stall_reg;

endmodule

// File: tb/tb_y86_reg_scoreboard.sv
module tb_y86_reg_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic [3:0]  srcA_i, srcB_i, dstE_i, dstM_i;
  logic        issue_ready_o;
  logic        wbE_valid_i;
  logic [3:0]  wbE_reg_i;
  logic        wbM_valid_i;
  logic [3:0]  wbM_reg_i;
  logic        drain_i;
  logic        drained_o;
  logic [14:0] busy_o;
  logic [15:0] stall_cnt_o;
  logic        clr_stats_i;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  y86_reg_scoreboard #(.NREG(15), .CNT_W(2), .STALL_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .issue_valid_i(issue_valid_i),
    .srcA_i(srcA_i), .srcB_i(srcB_i), .dstE_i(dstE_i), .dstM_i(dstM_i),
    .issue_ready_o(issue_ready_o), .wbE_valid_i(wbE_valid_i), .wbE_reg_i(wbE_reg_i),
    .wbM_valid_i(wbM_valid_i), .wbM_reg_i(wbM_reg_i), .drain_i(drain_i),
    .drained_o(drained_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o),
    .clr_stats_i(clr_stats_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [3:0]  sa, sb, de, dm;
    logic        we;
    logic [3:0]  wer;
    logic        wm;
    logic [3:0]  wmr;
    logic        drn, clr;
    logic        rdy;
    logic [14:0] busy;
    logic [15:0] stall;
    logic        drained, err;
  } vec_t;

  vec_t vt[28];

  function automatic vec_t mk(input logic iv, input logic [3:0] sa, sb, de, dm,
                              input logic we, input logic [3:0] wer,
                              input logic wm, input logic [3:0] wmr,
                              input logic drn, clr, rdy, input logic [14:0] busy,
                              input logic [15:0] stall, input logic drained, err);
    vec_t v;
    v.iv = iv; v.sa = sa; v.sb = sb; v.de = de; v.dm = dm;
    v.we = we; v.wer = wer; v.wm = wm; v.wmr = wmr;
    v.drn = drn; v.clr = clr; v.rdy = rdy; v.busy = busy;
    v.stall = stall; v.drained = drained; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0;
    srcA_i = 4'hF; srcB_i = 4'hF; dstE_i = 4'hF; dstM_i = 4'hF;
    wbE_valid_i = 1'b0; wbE_reg_i = 4'hF;
    wbM_valid_i = 1'b0; wbM_reg_i = 4'hF;
    drain_i = 1'b0; clr_stats_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [3:0] F = 4'hF;

  initial begin
    // Scoreboard walk: hazard, saturation, dual write, netting, underflow, drain.
    vt[0]  = mk(1,F,F,3,F, 0,F,0,F, 0,0, 1,15'h0008,16'd0,0,0);
    vt[1]  = mk(1,3,F,F,F, 0,F,0,F, 0,0, 0,15'h0008,16'd1,0,0);
    vt[2]  = mk(1,3,F,F,F, 0,F,0,F, 0,0, 0,15'h0008,16'd2,0,0);
    vt[3]  = mk(1,3,F,F,F, 1,3,0,F, 0,0, 0,15'h0000,16'd3,0,0);
    vt[4]  = mk(1,3,F,F,F, 0,F,0,F, 0,0, 1,15'h0000,16'd3,0,0);
    vt[5]  = mk(1,F,F,4,F, 0,F,0,F, 0,0, 1,15'h0010,16'd3,0,0);
    vt[6]  = mk(1,F,F,4,F, 0,F,0,F, 0,0, 1,15'h0010,16'd3,0,0);
    vt[7]  = mk(1,F,F,4,F, 0,F,0,F, 0,0, 1,15'h0010,16'd3,0,0);
    vt[8]  = mk(1,F,F,4,F, 0,F,0,F, 0,0, 0,15'h0010,16'd4,0,0);
    vt[9]  = mk(1,F,F,4,F, 1,4,0,F, 0,0, 0,15'h0010,16'd5,0,0);
    vt[10] = mk(1,F,F,4,4, 0,F,0,F, 0,0, 0,15'h0010,16'd6,0,0);
    vt[11] = mk(1,F,F,4,4, 1,4,0,F, 0,0, 0,15'h0010,16'd7,0,0);
    vt[12] = mk(1,F,F,4,4, 0,F,0,F, 0,0, 1,15'h0010,16'd7,0,0);
    vt[13] = mk(0,F,F,F,F, 1,4,1,4, 0,0, 1,15'h0010,16'd7,0,0);
    vt[14] = mk(0,F,F,F,F, 1,4,0,F, 0,0, 1,15'h0000,16'd7,0,0);
    vt[15] = mk(1,F,F,5,F, 0,F,0,F, 0,0, 1,15'h0020,16'd7,0,0);
    vt[16] = mk(1,F,F,5,F, 1,5,0,F, 0,0, 1,15'h0020,16'd7,0,0);
    vt[17] = mk(0,F,F,F,F, 0,F,1,2, 0,0, 1,15'h0020,16'd7,0,1);
    vt[18] = mk(0,F,F,F,F, 0,F,0,F, 0,0, 1,15'h0020,16'd7,0,1);
    vt[19] = mk(1,F,F,6,F, 0,F,0,F, 0,0, 1,15'h0060,16'd7,0,1);
    vt[20] = mk(1,F,F,F,F, 0,F,0,F, 1,0, 0,15'h0060,16'd8,0,1);
    vt[21] = mk(1,F,F,F,F, 1,5,0,F, 1,0, 0,15'h0040,16'd8,0,1);
    vt[22] = mk(0,F,F,F,F, 0,F,1,6, 1,0, 0,15'h0000,16'd8,0,1);
    vt[23] = mk(0,F,F,F,F, 0,F,0,F, 1,0, 0,15'h0000,16'd8,1,1);
    vt[24] = mk(0,F,F,F,F, 0,F,0,F, 1,0, 0,15'h0000,16'd8,1,1);
    vt[25] = mk(1,F,F,7,F, 0,F,0,F, 0,0, 0,15'h0000,16'd8,0,1);
    vt[26] = mk(1,F,F,F,F, 0,F,0,F, 0,0, 1,15'h0000,16'd8,0,1);
    vt[27] = mk(0,F,F,F,F, 0,F,0,F, 0,1, 1,15'h0000,16'd0,0,1);

    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_busy",    32'(busy_o),      32'h0);
    chk("reset_stall",   32'(stall_cnt_o), 32'h0);
    chk("reset_drained", 32'(drained_o),   32'h0);
    chk("reset_err",     32'(err_o),       32'h0);
    #2 rst_i = 1'b0;
    step();
    chk("reset_ready",   32'(issue_ready_o), 32'h1);

    for (int i = 0; i < 28; i++) begin
      issue_valid_i = vt[i].iv;
      srcA_i = vt[i].sa; srcB_i = vt[i].sb; dstE_i = vt[i].de; dstM_i = vt[i].dm;
      wbE_valid_i = vt[i].we; wbE_reg_i = vt[i].wer;
      wbM_valid_i = vt[i].wm; wbM_reg_i = vt[i].wmr;
      drain_i = vt[i].drn; clr_stats_i = vt[i].clr;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(issue_ready_o), 32'(vt[i].rdy));
      step();
      chk($sformatf("v%0d_busy", i),    32'(busy_o),      32'(vt[i].busy));
      chk($sformatf("v%0d_stall", i),   32'(stall_cnt_o), 32'(vt[i].stall));
      chk($sformatf("v%0d_drained", i), 32'(drained_o),   32'(vt[i].drained));
      chk($sformatf("v%0d_err", i),     32'(err_o),       32'(vt[i].err));
      $display("vec %0d: ready=%0b busy=%04h stall=%0d drained=%0b err=%0b",
               i, vt[i].rdy, busy_o, stall_cnt_o, drained_o, err_o);
    end

    // Reset mid-drain with writes outstanding and a nonzero stall count.
    idle_inputs();
    issue_valid_i = 1'b1; dstE_i = 4'h8;
    step();
    dstE_i = 4'hF; srcA_i = 4'h8;
    #1 chk("pre_rst_ready", 32'(issue_ready_o), 32'h0);
    step();
    chk("pre_rst_stall", 32'(stall_cnt_o), 32'd1);
    issue_valid_i = 1'b0; srcA_i = 4'hF; drain_i = 1'b1;
    step();
    chk("pre_rst_busy", 32'(busy_o), 32'h0100);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_busy",    32'(busy_o),      32'h0);
    chk("mid_rst_drained", 32'(drained_o),   32'h0);
    chk("mid_rst_stall",   32'(stall_cnt_o), 32'h0);
    chk("mid_rst_err",     32'(err_o),       32'h0);
    drain_i = 1'b0;
    #1 chk("mid_rst_ready", 32'(issue_ready_o), 32'h1);
    $display("mid-drain reset: busy=%04h drained=%0b stall=%0d err=%0b",
             busy_o, drained_o, stall_cnt_o, err_o);
    #1 rst_i = 1'b0;

    // Stall counter saturation, hold, then clear taking priority over a stall.
    step();
    issue_valid_i = 1'b1; dstE_i = 4'hA;
    step();
    dstE_i = 4'hF; srcA_i = 4'hA;
    repeat (65535) step();
    chk("sat_reach", 32'(stall_cnt_o), 32'hFFFF);
    repeat (3) step();
    chk("sat_hold", 32'(stall_cnt_o), 32'hFFFF);
    clr_stats_i = 1'b1;
    step();
    chk("sat_clear", 32'(stall_cnt_o), 32'h0);
    clr_stats_i = 1'b0;
    step();
    chk("post_clear_inc", 32'(stall_cnt_o), 32'd1);
    $display("saturation: stall=%0d after clear and one stalled cycle", stall_cnt_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
